// File: rtl/uart_mmio_bridge.sv
// rtl/uart_mmio_bridge.sv - memory-mapped UART bridge with RX/TX byte FIFOs and perf counters
// CPU reads are registered; FIFOs allow push-while-full when the opposite side pops in the same cycle.
module uart_mmio_bridge #(
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        instr_retired,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam int TXW = $clog2(TX_DEPTH);

  localparam logic [31:0] ADDR_STATUS  = 32'h8000_0000;
  localparam logic [31:0] ADDR_RXDATA  = 32'h8000_0004;
  localparam logic [31:0] ADDR_TXDATA  = 32'h8000_0008;
  localparam logic [31:0] ADDR_CYCLE   = 32'h8000_0010;
  localparam logic [31:0] ADDR_INSTRET = 32'h8000_0014;
  localparam logic [31:0] ADDR_CLEAR   = 32'h8000_0018;

  logic [7:0]   rx_mem_q [RX_DEPTH];
  logic [7:0]   tx_mem_q [TX_DEPTH];
  logic [RXW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [TXW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic         ovf_q, ovf_d;
  logic [31:0]  cyc_q, cyc_d, inst_q, inst_d;
  logic [31:0]  rdata_q, rdata_d, rd_val;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_pop, rx_push, tx_pop, tx_push, clr;
  logic unused_wdata;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[RXW] != rx_rp_q[RXW]) && (rx_wp_q[RXW-1:0] == rx_rp_q[RXW-1:0]);
  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[TXW] != tx_rp_q[TXW]) && (tx_wp_q[TXW-1:0] == tx_rp_q[TXW-1:0]);

  assign uart_rx_ready = ~rst;
  assign uart_tx_valid = ~tx_empty & ~rst;
  assign uart_tx_data  = tx_mem_q[tx_rp_q[TXW-1:0]];
  assign rdata         = rdata_q;
  assign unused_wdata  = ^wdata[31:8];

  assign rx_pop  = rd_en && (addr == ADDR_RXDATA) && !rx_empty;
  assign rx_push = uart_rx_valid && (!rx_full || rx_pop);
  assign tx_pop  = uart_tx_valid && uart_tx_ready;
  assign tx_push = wr_en && (addr == ADDR_TXDATA) && (!tx_full || tx_pop);
  assign clr     = wr_en && (addr == ADDR_CLEAR);

  always_comb begin
    rd_val = 32'd0;
    case (addr)
      ADDR_STATUS:  rd_val = {29'd0, ovf_q, ~rx_empty, ~tx_full};
      ADDR_RXDATA:  rd_val = rx_empty ? 32'd0 : {24'd0, rx_mem_q[rx_rp_q[RXW-1:0]]};
      ADDR_CYCLE:   rd_val = cyc_q;
      ADDR_INSTRET: rd_val = inst_q;
      default:      rd_val = 32'd0;
    endcase
  end

  always_comb begin
    rx_wp_d = rx_wp_q;
    rx_rp_d = rx_rp_q;
    tx_wp_d = tx_wp_q;
    tx_rp_d = tx_rp_q;
    ovf_d   = ovf_q;
    rdata_d = rd_en ? rd_val : rdata_q;
    cyc_d   = cyc_q + 32'd1;
    inst_d  = instr_retired ? inst_q + 32'd1 : inst_q;
    if (rx_push) rx_wp_d = rx_wp_q + 1'b1;
    if (rx_pop)  rx_rp_d = rx_rp_q + 1'b1;
    if (tx_push) tx_wp_d = tx_wp_q + 1'b1;
    if (tx_pop)  tx_rp_d = tx_rp_q + 1'b1;
    if (uart_rx_valid && rx_full && !rx_pop) ovf_d = 1'b1;
    if (clr) begin
      ovf_d  = 1'b0;
      cyc_d  = 32'd0;
      inst_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      ovf_q   <= 1'b0;
      cyc_q   <= 32'd0;
      inst_q  <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      rx_wp_q <= rx_wp_d;
      rx_rp_q <= rx_rp_d;
      tx_wp_q <= tx_wp_d;
      tx_rp_q <= tx_rp_d;
      ovf_q   <= ovf_d;
      cyc_q   <= cyc_d;
      inst_q  <= inst_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (!rst && rx_push) rx_mem_q[rx_wp_q[RXW-1:0]] <= uart_rx_data;
    if (!rst && tx_push) tx_mem_q[tx_wp_q[TXW-1:0]] <= wdata[7:0];
  end
endmodule
